// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the
// inverse column mixer.
package aes_pkg;

   localparam int BYTE = 8;
   localparam int WORD = 32;
   localparam int NCOL = 4;

   localparam logic [BYTE-1:0] GF_POLY = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Multiply by 0x02 modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
      return {b[BYTE-2:0], 1'b0} ^ (b[BYTE-1] ? GF_POLY : '0);
   endfunction

endpackage

// File: rtl/inv_col_mix.sv
// Single-column AES InvMixColumns: combinational, row0 in the top byte.
module inv_col_mix
   import aes_pkg::*;
(
   input  logic [WORD-1:0] col_in,
   output logic [WORD-1:0] col_out
);

   logic [BYTE-1:0] r  [NCOL];
   logic [BYTE-1:0] x2 [NCOL];
   logic [BYTE-1:0] x4 [NCOL];
   logic [BYTE-1:0] x8 [NCOL];
   logic [BYTE-1:0] m9 [NCOL];
   logic [BYTE-1:0] mb [NCOL];
   logic [BYTE-1:0] md [NCOL];
   logic [BYTE-1:0] me [NCOL];

   // 09/0b/0d/0e are sums of the x8, x4, x2 and x1 partial products.
   always_comb begin
      for (int i = 0; i < NCOL; i++) begin
         r[i]  = col_in[WORD-1-BYTE*i -: BYTE];
         x2[i] = xtime(r[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ r[i];
         mb[i] = x8[i] ^ x2[i] ^ r[i];
         md[i] = x8[i] ^ x4[i] ^ r[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      col_out = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                 m9[0] ^ me[1] ^ mb[2] ^ md[3],
                 md[0] ^ m9[1] ^ me[2] ^ mb[3],
                 mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   end

endmodule

// File: rtl/inv_mix_columns.sv
// Iterative AES InvMixColumns: one column per clock, result held on a
// valid/ready output until taken downstream.
//
//   state | meaning
//   IDLE  | waiting for a state on in_valid/in_ready
//   BUSY  | mixing column col_cnt in place, one per clock
//   DONE  | result presented on state_out until out_ready
module inv_mix_columns
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD*NCOL-1:0] state_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD*NCOL-1:0] state_out
);

   localparam int SW = WORD * NCOL;

   state_t          state_q;
   state_t          state_d;
   logic [1:0]      col_cnt;
   logic [SW-1:0]   state_reg;
   logic [WORD-1:0] col_sel;
   logic [WORD-1:0] col_mixed;
   logic            col_last;

   assign col_last = (col_cnt == 2'(NCOL - 1));

   always_comb begin
      col_sel = state_reg[SW-1 -: WORD];
      case (col_cnt)
         2'd0: col_sel = state_reg[SW-1         -: WORD];
         2'd1: col_sel = state_reg[SW-1-WORD    -: WORD];
         2'd2: col_sel = state_reg[SW-1-2*WORD  -: WORD];
         2'd3: col_sel = state_reg[SW-1-3*WORD  -: WORD];
         default: col_sel = state_reg[SW-1 -: WORD];
      endcase
   end

   inv_col_mix u_inv_col_mix (
      .col_in  (col_sel),
      .col_out (col_mixed)
   );

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (col_last) state_d = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // In-place write-back: the mixed column replaces its source slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_cnt   <= '0;
         state_reg <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  state_reg <= state_in;
                  col_cnt   <= '0;
               end
            end
            ST_BUSY: begin
               col_cnt <= col_cnt + 2'd1;
               case (col_cnt)
                  2'd0: state_reg[SW-1        -: WORD] <= col_mixed;
                  2'd1: state_reg[SW-1-WORD   -: WORD] <= col_mixed;
                  2'd2: state_reg[SW-1-2*WORD -: WORD] <= col_mixed;
                  2'd3: state_reg[SW-1-3*WORD -: WORD] <= col_mixed;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign state_out = state_reg;

endmodule
